// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, mode-register fields, bank state.
package sdram_pkg;

  typedef logic [3:0] cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam cmd_t CMD_INHIBIT         = 4'b1111;
  localparam cmd_t CMD_NOP             = 4'b0111;
  localparam cmd_t CMD_ACTIVE          = 4'b0011;
  localparam cmd_t CMD_READ            = 4'b0101;
  localparam cmd_t CMD_WRITE           = 4'b0100;
  localparam cmd_t CMD_BURST_TERMINATE = 4'b0110;
  localparam cmd_t CMD_PRECHARGE       = 4'b0010;
  localparam cmd_t CMD_AUTO_REFRESH    = 4'b0001;
  localparam cmd_t CMD_LOAD_MODE       = 4'b0000;

  localparam int MR_CL_LSB = 4;
  localparam int MR_CL_MSB = 6;
  localparam int AP_BIT    = 10;
  localparam int COL_W     = 9;
  localparam int ROW_W     = 13;

  typedef struct packed {
    logic             open;
    logic [ROW_W-1:0] row;
  } bank_t;

endpackage

// File: rtl/sdram_model_ram.sv
// Backing store for the SDRAM model: single port, byte-enable write, registered read.
module sdram_model_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  // No reset: contents survive a model reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_chip_model.sv
// Behavioural single-word SDRAM device model with CAS-latency read pipeline.
// Define SDRAM_MODEL_TIMING_CHECK_EN to build the sticky protocol checker on err.
module sdram_chip_model
  import sdram_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int INIT_CL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] a,
  input  logic [1:0]  dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [15:0] refresh_cnt,
  output logic        err
);

  cmd_t              cmd;
  bank_t [3:0]       bank_q, bank_d;
  logic  [2:0]       cl_q, cl_d;
  logic  [15:0]      ref_q, ref_d;
  logic  [1:0]       vld_pipe_q;
  logic              p0_cl3_q, p0_msk_q, p1_msk_q;
  logic  [15:0]      p1_data_q;
  logic              dq_oe_q;
  logic  [15:0]      dq_out_q;
  logic              all_idle, is_rd, is_wr, dqm_all, fire2, fire3;
  logic  [MEM_AW-1:0] ram_addr;
  logic  [15:0]      ram_rdata;

  assign cmd      = cs_n ? CMD_INHIBIT : {cs_n, ras_n, cas_n, we_n};
  assign is_rd    = !reset && (cmd == CMD_READ);
  assign is_wr    = !reset && (cmd == CMD_WRITE);
  assign dqm_all  = (dqm == 2'b11);
  assign ram_addr = MEM_AW'({ba, bank_q[ba].row, a[COL_W-1:0]});

  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < 4; i++)
      if (bank_q[i].open) all_idle = 1'b0;
  end

  always_comb begin
    bank_d = bank_q;
    cl_d   = cl_q;
    ref_d  = ref_q;
    case (cmd)
      CMD_ACTIVE: begin
        bank_d[ba].open = 1'b1;
        bank_d[ba].row  = a;
      end
      CMD_READ, CMD_WRITE:
        if (a[AP_BIT]) bank_d[ba].open = 1'b0;
      CMD_PRECHARGE:
        if (a[AP_BIT]) begin
          for (int i = 0; i < 4; i++) bank_d[i].open = 1'b0;
        end else begin
          bank_d[ba].open = 1'b0;
        end
      CMD_AUTO_REFRESH:
        if (all_idle) ref_d = ref_q + 16'd1;
      CMD_LOAD_MODE:
        if (all_idle) cl_d = a[MR_CL_MSB:MR_CL_LSB];
      default: ;
    endcase
  end

  // Stage 0 is the RAM output register; CL=3 reads take one extra hop through
  // stage 1. Any CL code other than 3 is timed as CL=2.
  assign fire2 = vld_pipe_q[0] && !p0_cl3_q;
  assign fire3 = vld_pipe_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q     <= '0;
      cl_q       <= 3'(INIT_CL);
      ref_q      <= '0;
      vld_pipe_q <= '0;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      bank_q     <= bank_d;
      cl_q       <= cl_d;
      ref_q      <= ref_d;
      vld_pipe_q <= {vld_pipe_q[0] && p0_cl3_q, is_rd};
      p0_cl3_q   <= (cl_q == 3'd3);
      p0_msk_q   <= dqm_all;
      p1_msk_q   <= dqm_all;
      p1_data_q  <= ram_rdata;
      dq_oe_q    <= (fire2 && !p0_msk_q) || (fire3 && !p1_msk_q);
      if (fire3 && !p1_msk_q)      dq_out_q <= p1_data_q;
      else if (fire2 && !p0_msk_q) dq_out_q <= ram_rdata;
    end
  end

  sdram_model_ram #(.AW(MEM_AW)) u_ram (
    .clk_i   (clk),
    .en_i    (is_rd || is_wr),
    .we_i    (is_wr),
    .be_i    (~dqm),
    .addr_i  (ram_addr),
    .wdata_i (dq_in),
    .rdata_o (ram_rdata)
  );

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign refresh_cnt = ref_q;

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
  logic [3:0] rcd_q;
  logic       err_q, viol;

  always_comb begin
    viol = 1'b0;
    case (cmd)
      CMD_ACTIVE:       viol = bank_q[ba].open;
      CMD_READ:         viol = !bank_q[ba].open || rcd_q[ba];
      CMD_WRITE:        viol = !bank_q[ba].open || rcd_q[ba] || (|vld_pipe_q);
      CMD_AUTO_REFRESH: viol = !all_idle;
      CMD_LOAD_MODE:    viol = !all_idle ||
                               !(a[MR_CL_MSB:MR_CL_LSB] inside {3'd2, 3'd3});
      default:          viol = 1'b0;
    endcase
  end

  // rcd_q marks banks activated on the previous edge (tRCD = 2).
  always_ff @(posedge clk) begin
    if (reset) begin
      rcd_q <= '0;
      err_q <= 1'b0;
    end else begin
      rcd_q <= (cmd == CMD_ACTIVE) ? (4'b0001 << ba) : 4'b0000;
      err_q <= err_q || viol;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/sdram_chip_model.md
SDRAM_CHIP_MODEL -- requirements
Module: sdram_chip_model

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning log2 of backing-store depth in 16-bit words.
REQ-002 SHALL have parameter INIT_CL, default 2, meaning CAS latency used before the first LOAD_MODE.
REQ-003 SHALL have port clk, input, 1 bit: device clock; all commands are sampled on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports cs_n, ras_n, cas_n and we_n, each input, 1 bit: command strobes.
REQ-006 SHALL have port ba, input, 2 bits: bank address.
REQ-007 SHALL have port a, input, 13 bits: multiplexed row/column/mode address.
REQ-008 SHALL have port dqm, input, 2 bits: byte masks; bit1 is the upper byte.
REQ-009 SHALL have port dq_in, input, 16 bits: write data from the controller.
REQ-010 SHALL have port dq_out, output, 16 bits: read data.
REQ-011 SHALL have port dq_oe, output, 1 bit: the model is driving dq_out.
REQ-012 SHALL have port refresh_cnt, output, 16 bits: count of accepted AUTO_REFRESH commands.
REQ-013 SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 SHALL decode {cs_n,ras_n,cas_n,we_n} per the shared command encodings.
- cs_n=1 or NOP: no operation.
- BURST_TERMINATE: ignored.
REQ-015 LOAD_MODE SHALL capture CL from a[6:4], accepted only when all banks are idle.
REQ-016 ACTIVE SHALL open bank ba with row a[12:0].
REQ-017 READ/WRITE SHALL use column a[8:0] and auto-precharge flag a[10].
REQ-018 The word index SHALL be {ba,row,col} truncated to its low MEM_AW bits.
REQ-019 WRITE SHALL store dq_in at the command edge into an open bank: dqm[0]=1 keeps the low byte, dqm[1]=1 keeps the high byte.
REQ-020 READ at edge N SHALL assert dq_oe with dq_out valid from just after edge N+CL-1 for exactly one cycle, so the controller samples it at edge N+CL.
REQ-021 Read data SHALL pass through a CL-deep pipeline that accepts one READ per cycle, back-to-back.
REQ-022 Read DQM latency SHALL be 2: dqm==2'b11 sampled at edge N+CL-2 suppresses dq_oe in the data cycle.
REQ-023 Auto-precharge (a[10]=1) SHALL return the bank to idle immediately after the command edge.
REQ-024 PRECHARGE with a[10]=1 SHALL idle all banks; with a[10]=0 it SHALL idle bank ba only.
REQ-025 AUTO_REFRESH with all banks idle SHALL increment refresh_cnt, wrapping 16'hFFFF->0.
REQ-026 When dq_oe=0, dq_out SHALL hold its last value.

Reset
REQ-027 Reset SHALL set dq_oe=0, dq_out=0, refresh_cnt=0 and err=0.
REQ-028 Reset SHALL idle all banks, flush the read pipeline and set CL=INIT_CL.
REQ-029 Reset SHALL retain memory contents; reset mid-read drops pending data.

Configuration
REQ-030 With SDRAM_MODEL_TIMING_CHECK_EN defined, the model SHALL set err on any of:
- READ/WRITE to an idle bank;
- ACTIVE to an open bank;
- READ/WRITE sooner than 2 cycles after its bank's ACTIVE (tRCD);
- AUTO_REFRESH or LOAD_MODE with any bank open;
- WRITE while read data is pending;
- CL field not 2 or 3.
REQ-031 Without the macro, err SHALL be tied to 0 and no checking logic SHALL be built.
REQ-032 Functional behaviour SHALL be identical with and without the macro; illegal commands are still executed as in REQ-014..REQ-025.

Structure
REQ-033 Package sdram_pkg SHALL hold:
- command encodings (INHIBIT, NOP, ACTIVE, READ, WRITE, BURST_TERMINATE, PRECHARGE, AUTO_REFRESH, LOAD_MODE);
- mode-register field positions;
- the bank-state typedef.
REQ-034 Storage SHALL be sub-module sdram_model_ram: single-port, 2^MEM_AW x 16, byte-enable write, registered read.

Verification
REQ-035 Reset; LOAD_MODE a=13'h0220; ACTIVE ba=1 row 0x012; 2 NOPs; WRITE col 0x034 a[10]=1 dq_in=16'hBEEF dqm=00; ACTIVE; READ -> dq_oe for 1 cycle, 16'hBEEF sampled at READ edge+2.
REQ-036 CL=3; back-to-back READs of words holding 16'h1111 and 16'h2222 -> data sampled at READ edges+3, consecutive cycles.
REQ-037 WRITE 16'hAABB with dqm=2'b10 over 16'h1234 -> readback 16'h12BB.
REQ-038 Three AUTO_REFRESH with banks idle -> refresh_cnt=3; with the macro, READ to an idle bank -> err=1 and it stays set.
REQ-039 Reset asserted one cycle after READ -> dq_oe stays 0, refresh_cnt=0, a prior write still reads back.
